// File: rtl/membus_pkg.sv
// -----------------------------------------------------------------------------
// membus_pkg
// Shared types and constants for the MemBus SRAM responder.
//   membus_resp_st_t : responder FSM states (ST_TA exists only when
//                      MEMBUS_RESP_TURNAROUND_EN is defined)
//   sram_ctl_t       : bundle of the registered SRAM control pins
//   MEMBUS_DW        : MemBus / SRAM data width
//   RD_CYC_DEF/WR_CYC_DEF : default strobe pulse lengths in clk cycles
// Configuration macro: MEMBUS_RESP_TURNAROUND_EN
// -----------------------------------------------------------------------------
package membus_pkg;

  localparam int unsigned MEMBUS_DW  = 16;
  localparam int unsigned RD_CYC_DEF = 2;
  localparam int unsigned WR_CYC_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SU,
    ST_WR_PW,
    ST_WR_HD
`ifdef MEMBUS_RESP_TURNAROUND_EN
    , ST_TA
`endif
  } membus_resp_st_t;

  // All SRAM control pins are registered together so they change on the
  // same edge and never glitch.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                     lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/membus_edge_pend.sv
// -----------------------------------------------------------------------------
// membus_edge_pend
// Rising-edge detector with a sticky pending flag. An edge seen while the
// responder is busy is remembered until the owner launches the access.
// Ports:
//   clk, rst (async, active-high)
//   strobe : level strobe from the initiator
//   clr    : launch acknowledge, clears the pending flag
//   start  : edge this cycle or an earlier edge still pending
// -----------------------------------------------------------------------------
module membus_edge_pend (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic clr,
  output logic start
);

  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic rise;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    rise   = strobe & ~prev_q;
    prev_d = strobe;
    pend_d = (pend_q | rise) & ~clr;
  end

  assign start = pend_q | rise;

  // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/membus_sram_resp.sv
// -----------------------------------------------------------------------------
// membus_sram_resp
// Responder end of the MemBus strobe interface driving a 16-bit async SRAM.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   addr[AW]          MemBus byte address (SRAM word address = addr[AW-1:1])
//   dati[16]          write data
//   oe, we_lo, we_hi  level read / byte-lane write strobes
//   dato[16]          registered read data, held until the next read completes
//   busy              access in progress (state != IDLE)
//   ram_addr[AW-1]    SRAM word address
//   ram_dq_i/o, ram_dq_oe  SRAM data bus split into in/out/enable
//   ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  SRAM controls, active-low
// Configuration macro: MEMBUS_RESP_TURNAROUND_EN adds a one-cycle TA state
// after every write so the data bus is dead for a cycle before a read.
// -----------------------------------------------------------------------------
module membus_sram_resp
  import membus_pkg::*;
#(
  parameter int unsigned AW     = 23,
  parameter int unsigned RD_CYC = RD_CYC_DEF,
  parameter int unsigned WR_CYC = WR_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  input  logic [MEMBUS_DW-1:0] dati,
  input  logic                 oe,
  input  logic                 we_lo,
  input  logic                 we_hi,
  output logic [MEMBUS_DW-1:0] dato,
  output logic                 busy,
  output logic [AW-2:0]        ram_addr,
  input  logic [MEMBUS_DW-1:0] ram_dq_i,
  output logic [MEMBUS_DW-1:0] ram_dq_o,
  output logic                 ram_dq_oe,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n,
  output logic                 ram_lb_n,
  output logic                 ram_ub_n
);

  localparam int unsigned CW = $clog2(max_u(RD_CYC, WR_CYC) + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);

  membus_resp_st_t      state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  sram_ctl_t            ctl_q, ctl_d;
  logic [AW-2:0]        ram_addr_q, ram_addr_d;
  logic [MEMBUS_DW-1:0] dq_o_q, dq_o_d;
  logic [MEMBUS_DW-1:0] dato_q, dato_d;
  logic [AW-2:0]        last_rd_q, last_rd_d;

  logic rd_edge_start, wr_edge_start;
  logic rd_start, wr_start;
  logic rd_clr, wr_clr;

  // Byte lanes come from the strobes, so the address LSB is not needed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr[0];

  membus_edge_pend u_rd_pend (
    .clk    (clk),
    .rst    (rst),
    .strobe (oe),
    .clr    (rd_clr),
    .start  (rd_edge_start)
  );

  membus_edge_pend u_wr_pend (
    .clk    (clk),
    .rst    (rst),
    .strobe (we_lo | we_hi),
    .clr    (wr_clr),
    .start  (wr_edge_start)
  );

  // With oe held high across back-to-back reads, a new word address is the trigger.
  assign rd_start = rd_edge_start | (oe & (addr[AW-1:1] != last_rd_q));
  assign wr_start = wr_edge_start;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctl_d      = ctl_q;
    ram_addr_d = ram_addr_q;
    dq_o_d     = dq_o_q;
    dato_d     = dato_q;
    last_rd_d  = last_rd_q;
    rd_clr     = 1'b0;
    wr_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Writes win a same-cycle tie; a pending read edge stays latched.
        if (wr_start) begin
          wr_clr     = 1'b1;
          ram_addr_d = addr[AW-1:1];
          dq_o_d     = dati;
          ctl_d      = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                         lb_n: ~we_lo, ub_n: ~we_hi, dq_oe: 1'b1};
          state_d    = ST_WR_SU;
        end else if (rd_start) begin
          rd_clr     = 1'b1;
          ram_addr_d = addr[AW-1:1];
          last_rd_d  = addr[AW-1:1];
          ctl_d      = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1,
                         lb_n: 1'b0, ub_n: 1'b0, dq_oe: 1'b0};
          cnt_d      = RD_LOAD;
          state_d    = ST_RD;
        end
      end

      ST_RD: begin
        if (cnt_q == '0) begin
          dato_d  = ram_dq_i;
          ctl_d   = CTL_IDLE;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR_SU: begin
        ctl_d.we_n = 1'b0;
        cnt_d      = WR_LOAD;
        state_d    = ST_WR_PW;
      end

      ST_WR_PW: begin
        if (cnt_q == '0) begin
          ctl_d.we_n = 1'b1;
          state_d    = ST_WR_HD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR_HD: begin
`ifdef MEMBUS_RESP_TURNAROUND_EN
        // Chip stays selected but nothing is driven or strobed for one cycle.
        ctl_d   = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                    lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};
        state_d = ST_TA;
`else
        ctl_d   = CTL_IDLE;
        state_d = ST_IDLE;
`endif
      end

`ifdef MEMBUS_RESP_TURNAROUND_EN
      ST_TA: begin
        ctl_d   = CTL_IDLE;
        state_d = ST_IDLE;
      end
`endif

      default: begin
        ctl_d   = CTL_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ctl_q      <= CTL_IDLE;
      ram_addr_q <= '0;
      dq_o_q     <= '0;
      dato_q     <= '0;
      last_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctl_q      <= ctl_d;
      ram_addr_q <= ram_addr_d;
      dq_o_q     <= dq_o_d;
      dato_q     <= dato_d;
      last_rd_q  <= last_rd_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dato      = dato_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dq_o  = dq_o_q;
  assign ram_dq_oe = ctl_q.dq_oe;
  assign ram_ce_n  = ctl_q.ce_n;
  assign ram_oe_n  = ctl_q.oe_n;
  assign ram_we_n  = ctl_q.we_n;
  assign ram_lb_n  = ctl_q.lb_n;
  assign ram_ub_n  = ctl_q.ub_n;

endmodule
